// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: shadow codes, dead-time anode scan, BCD/hex decode.
// Optional leading-zero blanking when SEG_LZ_BLANK_EN is defined.
module seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 2,
    parameter int HEX_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    input  logic [4*DIGITS-1:0] digits_in,
    input  logic [DIGITS-1:0]   dp_in,
    output logic [6:0]          seg,
    output logic                dp_n,
    output logic [DIGITS-1:0]   an_n,
    output logic                frame_tick
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
    localparam logic [PW-1:0] LAST_PRESC = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] DEAD_END   = PW'(DEAD);

    logic [IW-1:0]            idx_q, idx_d;
    logic [PW-1:0]            presc_q, presc_d;
    logic [DIGITS-1:0][3:0]   dig_q, dig_d;
    logic [DIGITS-1:0]        dp_q, dp_d;
    logic [6:0]               seg_q, seg_d;
    logic                     dp_n_q, dp_n_d;
    logic [DIGITS-1:0]        an_n_q, an_n_d;
    logic                     tick_q, tick_d;
    logic [DIGITS-1:0]        sel;
    logic [DIGITS-1:0]        blank;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        if (HEX_MODE == 0 && code > 4'h9) s = 7'b1111111;
        return s;
    endfunction

`ifdef SEG_LZ_BLANK_EN
    // A digit blanks when it and everything above it is zero; digit 0 never does.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank    = '0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run & (dig_q[k] == 4'h0);
            blank[k] = zero_run;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        idx_d   = idx_q;
        presc_d = presc_q;
        dig_d   = load ? digits_in : dig_q;
        dp_d    = load ? dp_in : dp_q;
        seg_d   = 7'b1111111;
        dp_n_d  = 1'b1;
        an_n_d  = '1;
        tick_d  = 1'b0;
        sel     = '0;
        sel[idx_q] = 1'b1;
        if (en) begin
            if (presc_q == LAST_PRESC) begin
                presc_d = '0;
                tick_d  = (idx_q == LAST_IDX);
                idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
            if (presc_q >= DEAD_END) begin
                an_n_d = ~sel;
                seg_d  = blank[idx_q] ? 7'b1111111 : decode(dig_q[idx_q]);
                dp_n_d = ~dp_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            presc_q <= '0;
            dig_q   <= '0;
            dp_q    <= '0;
            seg_q   <= 7'b1111111;
            dp_n_q  <= 1'b1;
            an_n_q  <= '1;
            tick_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            presc_q <= presc_d;
            dig_q   <= dig_d;
            dp_q    <= dp_d;
            seg_q   <= seg_d;
            dp_n_q  <= dp_n_d;
            an_n_q  <= an_n_d;
            tick_q  <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign frame_tick = tick_q;

endmodule
